// File: rtl/rca_io_unit_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rca_config (package)
// Brief    : Shared defaults and types for the grid I/O unit bank.
// Revision : 1.0 - initial release
// ============================================================================
package rca_config;

    localparam int IO_FIFO_DEPTH      = 4;
    localparam int IO_UNIT_MUX_INPUTS = 6;

    typedef enum logic {
        IO_MODE_PASSTHROUGH = 1'b0,
        IO_MODE_FIFO        = 1'b1
    } io_mode_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic full;
    } io_fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/rca_io_unit_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : rca_io_unit_bank_if
// Brief    : Source/control and output bundle of the grid I/O unit bank.
// Revision : 1.0 - initial release
// ============================================================================
interface rca_io_unit_bank_if #(
    parameter int XLEN         = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int NUM_SRC      = 6,
    parameter int FIFO_DEPTH   = 4
);
    localparam int c_sel_w = $clog2(NUM_SRC);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

    logic [NUM_SRC-1:0][XLEN-1:0]         src_data;
    logic [NUM_CHANNELS-1:0][NUM_SRC-1:0] src_valid;
    logic [NUM_CHANNELS-1:0][c_sel_w-1:0] src_sel;
    logic [NUM_CHANNELS-1:0]              output_mode;
    logic                                 fifo_flush;
    logic [NUM_CHANNELS-1:0]              fifo_pop;

    logic [NUM_CHANNELS-1:0][XLEN-1:0]    data_out;
    logic [NUM_CHANNELS-1:0]              data_valid_out;
    logic [NUM_CHANNELS-1:0][c_cnt_w-1:0] fifo_count;
    logic [NUM_CHANNELS-1:0]              fifo_full;
    logic [NUM_CHANNELS-1:0]              overflow;
    logic [NUM_CHANNELS-1:0]              underflow;

    modport master (
        output src_data, src_valid, src_sel, output_mode, fifo_flush, fifo_pop,
        input  data_out, data_valid_out, fifo_count, fifo_full, overflow, underflow
    );

    modport slave (
        input  src_data, src_valid, src_sel, output_mode, fifo_flush, fifo_pop,
        output data_out, data_valid_out, fifo_count, fifo_full, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/rca_io_unit_bank_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rca_io_fifo
// Brief    : Per-channel FWFT FIFO with occupancy count and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module rca_io_fifo
    import rca_config::*;
#(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = IO_FIFO_DEPTH,
    localparam int c_ptr_w   = $clog2(FIFO_DEPTH),
    localparam int c_cnt_w   = $clog2(FIFO_DEPTH + 1)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_flush,
    input  wire logic               i_push,
    input  wire logic [XLEN-1:0]    i_push_data,
    input  wire logic               i_pop_req,
    output logic [XLEN-1:0]         o_head_data,
    output logic                    o_head_valid,
    output logic [c_cnt_w-1:0]      o_count,
    output io_fifo_status_t         o_status
);

    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    logic [XLEN-1:0]    r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    assign w_pop   = i_pop_req && !w_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            // An empty pop is flagged even when a push lands in the same cycle.
            if (i_pop_req && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_head_data        = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_head_valid       = !w_empty;
    assign o_count            = r_count;
    assign o_status.overflow  = r_overflow;
    assign o_status.underflow = r_underflow;
    assign o_status.full      = w_full;

endmodule
`default_nettype wire

// File: rtl/rca_io_unit_bank.sv
`default_nettype none
// ============================================================================
// Module   : rca_io_unit_bank
// Brief    : Bank of grid I/O channels: source mux, passthrough register, FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module rca_io_unit_bank
    import rca_config::*;
#(
    parameter int XLEN         = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int NUM_SRC      = IO_UNIT_MUX_INPUTS,
    parameter int FIFO_DEPTH   = IO_FIFO_DEPTH
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rca_io_unit_bank_if.slave  bus
);

    localparam int c_sel_w = $clog2(NUM_SRC);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [XLEN-1:0]    w_sel_data;
        logic               w_sel_valid;
        io_mode_t           w_mode;
        logic [XLEN-1:0]    r_pt_data;
        logic               r_pt_valid;
        logic [XLEN-1:0]    w_head_data;
        logic               w_head_valid;
        logic [c_cnt_w-1:0] w_count;
        io_fifo_status_t    w_status;

        assign w_mode = io_mode_t'(bus.output_mode[c]);

        // Out-of-range selects match no source and yield zero/invalid.
        always_comb begin
            w_sel_data  = '0;
            w_sel_valid = 1'b0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (bus.src_sel[c] == s[c_sel_w-1:0]) begin
                    w_sel_data  = bus.src_data[s];
                    w_sel_valid = bus.src_valid[c][s];
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_pt_data  <= '0;
                r_pt_valid <= 1'b0;
            end else begin
                r_pt_data  <= w_sel_data;
                r_pt_valid <= bus.fifo_flush ? 1'b0 : w_sel_valid;
            end
        end

        rca_io_fifo #(
            .XLEN       (XLEN),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk          (clk),
            .rst          (rst),
            .i_flush      (bus.fifo_flush),
            .i_push       ((w_mode == IO_MODE_FIFO) && w_sel_valid),
            .i_push_data  (w_sel_data),
            .i_pop_req    ((w_mode == IO_MODE_FIFO) && bus.fifo_pop[c]),
            .o_head_data  (w_head_data),
            .o_head_valid (w_head_valid),
            .o_count      (w_count),
            .o_status     (w_status)
        );

        assign bus.data_out[c]       = (w_mode == IO_MODE_FIFO) ? w_head_data  : r_pt_data;
        assign bus.data_valid_out[c] = (w_mode == IO_MODE_FIFO) ? w_head_valid : r_pt_valid;
        assign bus.fifo_count[c]     = w_count;
        assign bus.fifo_full[c]      = w_status.full;
        assign bus.overflow[c]       = w_status.overflow;
        assign bus.underflow[c]      = w_status.underflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_rca_io_unit_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_io_unit_bank
// Brief    : Directed self-checking bench for the grid I/O unit bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rca_io_unit_bank;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    rca_io_unit_bank_if #(.XLEN(32), .NUM_CHANNELS(4), .NUM_SRC(6), .FIFO_DEPTH(4)) bus ();

    rca_io_unit_bank #(
        .XLEN         (32),
        .NUM_CHANNELS (4),
        .NUM_SRC      (6),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [5:0]  valid;
        logic [31:0] exp_data;
        logic        exp_valid;
    } pt_vec_t;

    pt_vec_t     vecs [7];
    logic [31:0] exp_b [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [31:0] d, input logic pp);
        bus.src_sel[0]   = 3'd2;
        bus.src_data[2]  = d;
        bus.src_valid[0] = pv ? 6'b000100 : 6'b000000;
        bus.fifo_pop[0]  = pp;
        step();
    endtask

    task automatic flush_all();
        bus.fifo_flush = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        bus.fifo_flush = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b0;
        bus.src_data[0]  = 32'h0A0A0A0A;
        bus.src_data[1]  = 32'h11111111;
        bus.src_data[2]  = 32'hDEADBEEF;
        bus.src_data[3]  = 32'h33333333;
        bus.src_data[4]  = 32'h44444444;
        bus.src_data[5]  = 32'h55555555;
        bus.src_valid    = '0;
        for (int c = 0; c < 4; c++) bus.src_sel[c] = 3'd7;
        bus.output_mode  = '0;
        bus.fifo_flush   = 1'b0;
        bus.fifo_pop     = '0;

        vecs[0] = '{3'd2, 6'b000100, 32'hDEADBEEF, 1'b1};
        vecs[1] = '{3'd3, 6'b000100, 32'h33333333, 1'b0};
        vecs[2] = '{3'd5, 6'b100000, 32'h55555555, 1'b1};
        vecs[3] = '{3'd0, 6'b111111, 32'h0A0A0A0A, 1'b1};
        vecs[4] = '{3'd7, 6'b111111, 32'h00000000, 1'b0};
        vecs[5] = '{3'd6, 6'b111111, 32'h00000000, 1'b0};
        vecs[6] = '{3'd1, 6'b000010, 32'h11111111, 1'b1};

        #12;
        for (int c = 0; c < 4; c++) chk("rst_data", bus.data_out[c], 32'h0);
        chk("rst_flags", 32'({bus.data_valid_out, bus.fifo_full, bus.overflow, bus.underflow}), 32'h0);
        chk("rst_count", 32'(bus.fifo_count), 32'h0);

        @(posedge clk);
        #1 rst = 1'b1;

        // Passthrough and source mux table on channel 0
        for (int i = 0; i < 7; i++) begin
            bus.src_sel[0]   = vecs[i].sel;
            bus.src_valid[0] = vecs[i].valid;
            step();
            chk($sformatf("pt_data[%0d]", i), bus.data_out[0], vecs[i].exp_data);
            chk($sformatf("pt_valid[%0d]", i), 32'(bus.data_valid_out[0]), 32'(vecs[i].exp_valid));
        end
        for (int c = 1; c < 4; c++) begin
            chk("other_data", bus.data_out[c], 32'h0);
            chk("other_valid", 32'(bus.data_valid_out[c]), 32'h0);
        end

        // Fill to overflow
        bus.src_valid[0]   = '0;
        bus.output_mode[0] = 1'b1;
        flush_all();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 32'(k), 1'b0);
            chk($sformatf("fill_count[%0d]", k), 32'(bus.fifo_count[0]), (k > 4) ? 32'd4 : 32'(k));
            chk($sformatf("fill_ovf[%0d]", k), 32'(bus.overflow[0]), (k > 4) ? 32'd1 : 32'd0);
        end
        chk("fill_full", 32'(bus.fifo_full[0]), 32'd1);
        drive(1'b0, 32'h0, 1'b0);
        chk("hold_data", bus.data_out[0], 32'h1);
        chk("hold_valid", 32'(bus.data_valid_out[0]), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain_a[%0d]", k), bus.data_out[0], 32'(k));
            drive(1'b0, 32'h0, 1'b1);
        end
        chk("drain_a_valid", 32'(bus.data_valid_out[0]), 32'd0);
        chk("drain_a_count", 32'(bus.fifo_count[0]), 32'd0);
        chk("drain_a_unf", 32'(bus.underflow[0]), 32'd0);
        chk("ovf_sticky", 32'(bus.overflow[0]), 32'd1);

        // Full with simultaneous push and pop
        flush_all();
        chk("flush_ovf", 32'(bus.overflow[0]), 32'd0);
        for (int k = 1; k <= 4; k++) drive(1'b1, 32'(k), 1'b0);
        drive(1'b1, 32'hA, 1'b1);
        chk("fullpp_count", 32'(bus.fifo_count[0]), 32'd4);
        chk("fullpp_ovf", 32'(bus.overflow[0]), 32'd0);
        exp_b[0] = 32'h2; exp_b[1] = 32'h3; exp_b[2] = 32'h4; exp_b[3] = 32'hA;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_b[%0d]", k), bus.data_out[0], exp_b[k]);
            drive(1'b0, 32'h0, 1'b1);
        end

        // Empty pop, then push/pop pairs across pointer wrap
        drive(1'b0, 32'h0, 1'b1);
        chk("emp_unf", 32'(bus.underflow[0]), 32'd1);
        chk("emp_count", 32'(bus.fifo_count[0]), 32'd0);
        drive(1'b1, 32'h10, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            chk($sformatf("wrap_head[%0d]", i), bus.data_out[0], 32'h10 + 32'(i) - 32'd1);
            drive(1'b1, 32'h10 + 32'(i), 1'b1);
            chk($sformatf("wrap_count[%0d]", i), 32'(bus.fifo_count[0]), 32'd1);
        end
        chk("wrap_last", bus.data_out[0], 32'h19);
        drive(1'b0, 32'h0, 1'b1);
        chk("wrap_empty", 32'(bus.fifo_count[0]), 32'd0);

        // Empty FIFO: pop and push together
        flush_all();
        drive(1'b1, 32'h55, 1'b1);
        chk("epp_unf", 32'(bus.underflow[0]), 32'd1);
        chk("epp_count", 32'(bus.fifo_count[0]), 32'd1);
        chk("epp_head", bus.data_out[0], 32'h55);

        // Flush priority over a same-cycle push
        flush_all();
        for (int k = 1; k <= 5; k++) drive(1'b1, 32'(k), 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        chk("pre_flush_count", 32'(bus.fifo_count[0]), 32'd3);
        chk("pre_flush_ovf", 32'(bus.overflow[0]), 32'd1);
        bus.fifo_flush = 1'b1;
        drive(1'b1, 32'h77, 1'b0);
        bus.fifo_flush = 1'b0;
        chk("flush_count", 32'(bus.fifo_count[0]), 32'd0);
        chk("flush_valid", 32'(bus.data_valid_out[0]), 32'd0);
        chk("flush_ovf2", 32'(bus.overflow[0]), 32'd0);
        drive(1'b0, 32'h0, 1'b0);
        chk("no_77_data", bus.data_out[0], 32'h0);
        chk("no_77_count", 32'(bus.fifo_count[0]), 32'd0);
        bus.fifo_flush = 1'b1;
        drive(1'b0, 32'h0, 1'b1);
        bus.fifo_flush = 1'b0;
        chk("flush_pop_unf", 32'(bus.underflow[0]), 32'd0);

        // Mode switching: FIFO frozen in passthrough, head visible on return
        drive(1'b1, 32'h21, 1'b0);
        drive(1'b1, 32'h22, 1'b0);
        bus.output_mode[0] = 1'b0;
        drive(1'b1, 32'h99, 1'b1);
        chk("frz_data", bus.data_out[0], 32'h99);
        chk("frz_count", 32'(bus.fifo_count[0]), 32'd2);
        chk("frz_unf", 32'(bus.underflow[0]), 32'd0);
        bus.src_valid[0]   = '0;
        bus.fifo_pop[0]    = 1'b0;
        bus.output_mode[0] = 1'b1;
        #1;
        chk("ret_head", bus.data_out[0], 32'h21);
        chk("ret_valid", 32'(bus.data_valid_out[0]), 32'd1);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_data", bus.data_out[0], 32'h0);
        chk("arst_valid", 32'(bus.data_valid_out[0]), 32'd0);
        chk("arst_count", 32'(bus.fifo_count[0]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        chk("post_rst_valid", 32'(bus.data_valid_out[0]), 32'd0);
        chk("ch1_count", 32'(bus.fifo_count[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
